// File: rtl/tug_field_pkg.sv
// ---------------------------------------------------------------------------
// tug_pkg : shared types and constants for the tug_field playfield stage.
//   field_state_t : playfield FSM state (PLAY / LOCKED)
//   pos_t         : light position for the default 9-LED bar
//   CENTER_POS    : LED lit after reset or restart
// ---------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic {
    PLAY   = 1'b0,
    LOCKED = 1'b1
  } field_state_t;

  typedef logic [3:0] pos_t;

  localparam pos_t CENTER_POS      = 4'd5;
  localparam int   NUM_LEDS_DEF    = 9;
  localparam int   SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/tug_field_if.sv
// ---------------------------------------------------------------------------
// tug_field_if : key / restart inputs and playfield outputs of tug_field.
//   L_key, R_key : raw player keys (level, asynchronous)
//   restart      : recentre request from the scorekeeper
//   led          : one-hot playfield bar, bit i-1 drives LED i
//   l_press      : one-cycle pulse per accepted left press
//   r_press      : one-cycle pulse per accepted right press
// master = key/scorekeeper side, slave = playfield block.
// ---------------------------------------------------------------------------
interface tug_field_if #(
  parameter int NUM_LEDS = 9
);
  logic                L_key;
  logic                R_key;
  logic                restart;
  logic [NUM_LEDS-1:0] led;
  logic                l_press;
  logic                r_press;

  modport master (
    output L_key, R_key, restart,
    input  led, l_press, r_press
  );

  modport slave (
    input  L_key, R_key, restart,
    output led, l_press, r_press
  );
endinterface

// File: rtl/tug_field_key_edge.sv
// ---------------------------------------------------------------------------
// key_edge : synchroniser plus rising-edge detector for one raw key.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   key   : raw key level, asynchronous to clk
//   rise  : high for one cycle per synchronised 0->1 transition
// A warm-up shift register holds the detector quiet until both the
// synchroniser and the "previous" flop carry real key samples, so a key
// already held when reset releases never produces an edge.
// ---------------------------------------------------------------------------
module key_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [SYNC_STAGES:0]   warm_r;

  // Synchroniser chain, previous-level flop and warm-up tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
      warm_r <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key};
      prev_r <= sync_r[SYNC_STAGES-1];
      warm_r <= {warm_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // warm_r[SYNC_STAGES] is set once prev_r holds a genuine sampled level.
  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r & warm_r[SYNC_STAGES];

endmodule

// File: rtl/tug_field.sv
// ---------------------------------------------------------------------------
// tug_field : playfield stage of the Cyber War game.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : tug_field_if.slave (L_key, R_key, restart in; led, l_press,
//           r_press out, all outputs registered)
// Key edges become single-cycle press pulses; a press moves the lit LED one
// step on the following clock, so the scorekeeper sees led together with
// the press at the pre-move position. Reaching an end locks the field until
// restart recentres it.
// ---------------------------------------------------------------------------
module tug_field
  import tug_pkg::*;
#(
  parameter int NUM_LEDS    = NUM_LEDS_DEF,
  parameter int CENTER      = int'(CENTER_POS),
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  tug_field_if.slave bus
);

  localparam int                  POS_W      = $clog2(NUM_LEDS + 1);
  localparam logic [POS_W-1:0]    CENTER_P   = POS_W'(CENTER);
  localparam logic [POS_W-1:0]    LAST_P     = POS_W'(NUM_LEDS);
  localparam logic [POS_W-1:0]    ONE_P      = POS_W'(1);
  localparam logic [NUM_LEDS-1:0] CENTER_LED = NUM_LEDS'(1) << (CENTER - 1);

  logic                l_rise_s;
  logic                r_rise_s;
  field_state_t        state_r;
  field_state_t        state_nxt_s;
  logic [POS_W-1:0]    pos_r;
  logic [POS_W-1:0]    pos_nxt_s;
  logic                l_press_r;
  logic                r_press_r;
  logic                l_press_nxt_s;
  logic                r_press_nxt_s;
  logic [NUM_LEDS-1:0] led_r;
  logic [NUM_LEDS-1:0] led_nxt_s;

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_l_edge (
    .clk   (clk),
    .reset (reset),
    .key   (bus.L_key),
    .rise  (l_rise_s)
  );

  key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_r_edge (
    .clk   (clk),
    .reset (reset),
    .key   (bus.R_key),
    .rise  (r_rise_s)
  );

  // State, position and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= PLAY;
      pos_r     <= CENTER_P;
      l_press_r <= 1'b0;
      r_press_r <= 1'b0;
      led_r     <= CENTER_LED;
    end else begin
      state_r   <= state_nxt_s;
      pos_r     <= pos_nxt_s;
      l_press_r <= l_press_nxt_s;
      r_press_r <= r_press_nxt_s;
      led_r     <= led_nxt_s;
    end
  end

  // Next state and position, driven by the already-registered press pulses.
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    if (bus.restart) begin
      state_nxt_s = PLAY;
      pos_nxt_s   = CENTER_P;
    end else begin
      case (state_r)
        PLAY: begin
          if (l_press_r) begin
            if (pos_r < LAST_P) begin
              pos_nxt_s = pos_r + ONE_P;
            end else begin
              state_nxt_s = LOCKED;
            end
          end else if (r_press_r) begin
            if (pos_r > ONE_P) begin
              pos_nxt_s = pos_r - ONE_P;
            end else begin
              state_nxt_s = LOCKED;
            end
          end else begin
            state_nxt_s = PLAY;
          end
        end
        LOCKED: begin
          state_nxt_s = LOCKED;
        end
        default: begin
          state_nxt_s = PLAY;
          pos_nxt_s   = CENTER_P;
        end
      endcase
    end
  end

  // Press qualification (simultaneous edges cancel) and one-hot LED decode.
  always_comb begin
    l_press_nxt_s = 1'b0;
    r_press_nxt_s = 1'b0;
    led_nxt_s     = {NUM_LEDS{1'b0}};
    if ((state_r == PLAY) && !bus.restart) begin
      l_press_nxt_s = l_rise_s & ~r_rise_s;
      r_press_nxt_s = r_rise_s & ~l_rise_s;
    end else begin
      l_press_nxt_s = 1'b0;
      r_press_nxt_s = 1'b0;
    end
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_nxt_s[i] = (pos_nxt_s == POS_W'(i + 1));
    end
  end

  assign bus.led     = led_r;
  assign bus.l_press = l_press_r;
  assign bus.r_press = r_press_r;

endmodule
